// File: rtl/comparator_4bit_checker.sv
// comparator_4bit_checker: exhaustive 256-vector sweep of an external 4-bit comparator
// with mismatch count and first-failing-vector capture.
module comparator_4bit_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    input  logic       e_in,
    input  logic       g_in,
    input  logic       l_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [7:0] first_fail,
    output logic       first_fail_valid
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [7:0] vec;
    logic [2:0] exp_resp;
    logic mismatch, last, accept, sample;
    assign a_out = vec[7:4];
    assign b_out = vec[3:0];
    assign exp_resp = {a_out == b_out, a_out > b_out, a_out < b_out};
    assign mismatch = {e_in, g_in, l_in} != exp_resp;
    assign last = vec == 8'hff;
    assign accept = state == IDLE && start;
    assign sample = state == SAMPLE;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start ? DRIVE : IDLE) :
                   (state == DRIVE) ? ((cnt == SETTLE_M1) ? SAMPLE : DRIVE) :
                   (last ? IDLE : DRIVE);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            vec <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            err_count <= '0;
            first_fail <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            cnt <= (state == DRIVE) ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                vec <= '0;
                busy <= 1'b1;
                done <= 1'b0;
                pass <= 1'b0;
                err_count <= '0;
                first_fail_valid <= 1'b0;
            end
            if (sample) begin
                if (mismatch && err_count != 9'd256) err_count <= err_count + 9'd1;
                if (mismatch && !first_fail_valid) begin
                    first_fail <= vec;
                    first_fail_valid <= 1'b1;
                end
                // the final vector's outcome is folded into pass directly since err_count updates on the same edge
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= err_count == 9'd0 && !mismatch;
                end else begin
                    vec <= vec + 8'd1;
                end
            end
        end
    end
endmodule

// File: doc/comparator_4bit_checker.md
COMPARATOR_4BIT_CHECKER -- requirements
Module: comparator_4bit_checker

Interface
REQ-001 Parameter: SETTLE, default 2, number of cycles each vector is held before the DUT response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle request to begin an exhaustive sweep.
REQ-005 a_out  output  4  operand A driven to the comparator under test.
REQ-006 b_out  output  4  operand B driven to the comparator under test.
REQ-007 e_in, g_in, l_in  input  1 each  DUT equal, greater, less responses.
REQ-008 busy  output  1  sweep in progress.
REQ-009 done  output  1  sweep complete; sticky until the next accepted start or reset.
REQ-010 pass  output  1  valid with done; 1 means zero mismatches.
REQ-011 err_count  output  9  mismatching vectors in the current or last sweep, 0..256.
REQ-012 first_fail  output  8  {a,b} of the first mismatching vector.
REQ-013 first_fail_valid  output  1  first_fail holds a captured vector.

Function
REQ-014 The FSM SHALL use states IDLE, DRIVE and SAMPLE.
REQ-015 In IDLE, start=1 at a rising edge SHALL clear vec, err_count, done, pass and first_fail_valid, set busy, and enter DRIVE.
REQ-016 {a_out,b_out} SHALL be registered and equal vec[7:4],vec[3:0] throughout DRIVE and SAMPLE.
REQ-017 DRIVE SHALL last exactly SETTLE cycles and then enter SAMPLE.
REQ-018 SAMPLE SHALL last one cycle; at its closing edge the block SHALL compare {e_in,g_in,l_in} to the expected value {a==b, a>b, a<b} (unsigned).
REQ-019 Any bit difference SHALL count as a mismatch, including none-hot and multi-hot responses.
REQ-020 On a mismatch, err_count SHALL increment by 1; if first_fail_valid=0, first_fail SHALL capture {a_out,b_out} and first_fail_valid SHALL be set.
REQ-021 At the SAMPLE closing edge with vec<255, vec SHALL increment and the FSM SHALL enter DRIVE.
REQ-022 At the SAMPLE closing edge with vec=255, the FSM SHALL enter IDLE, busy SHALL fall, done SHALL rise, and pass SHALL equal (final err_count==0); no wrap past 255.
REQ-023 Vector n SHALL enter DRIVE at edge n*(SETTLE+1) after the start edge; done SHALL rise at edge 256*(SETTLE+1).
REQ-024 start SHALL be ignored while busy=1.
REQ-025 start in IDLE with done=1 SHALL begin a new sweep and clear the previous results per REQ-015.
REQ-026 err_count SHALL reach at most 256 and SHALL never wrap.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, vec=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0 and first_fail_valid=0, independent of clk.
REQ-028 rst asserted mid-sweep SHALL abandon the sweep with no partial done or pass indication.
REQ-029 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-030 Correct comparator model, SETTLE=2, start pulse -> done at edge 768, pass=1, err_count=0, first_fail_valid=0.
REQ-031 Model with g/l swapped -> err_count=240, first_fail=8'h01, first_fail_valid=1, pass=0.
REQ-032 Model with e stuck at 0 -> err_count=16, first_fail=8'h00, pass=0.
REQ-033 start re-pulsed while vec=10 -> ignored; done still at edge 768, err_count unaffected.
REQ-034 rst pulsed asynchronously at vec=100 -> all outputs 0 before the next edge; a new start then completes a full 256-vector sweep.
REQ-035 SETTLE=1 with correct model -> each vector held 2 cycles, done at edge 512, pass=1.
